fifo_param: RTL and testbench

Parametrised synchronous single-clock FIFO. Successor to the fixed 32x8 FIFO, generalised in data width and depth.
- Adds programmable almost-full and almost-empty flags.
- Adds a full-range occupancy counter that can represent DEPTH.
- Adds an optional sticky overflow/underflow error reporting feature.
- Sits between byte/word producers and consumers in the datapath.

---
 rtl/fifo_param.sv | 154 +++++++++++++++
 tb/tb_fifo_param.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// fifo_param: parameterised single-clock synchronous FIFO.
//
// Purpose:
//   Buffers WIDTH-bit words between a producer and a consumer. Read data is
//   registered, so it appears one cycle after the accepting edge. Occupancy
//   USE_DW spans the full range 0..DEPTH. Full, empty, almost-full and
//   almost-empty flags are all registered, so no input has a combinational
//   path to any output.
//
// Optional build macro:
//   FIFO_PARAM_ERR_FLAGS_EN - adds sticky OVF/UDF error outputs. OVF sets on a
//   rejected write and UDF on a rejected read. Both clear only on RESET_N or
//   CLEAR_N.
//
// Ports:
//   CLOCK       in   rising-edge clock
//   RESET_N     in   asynchronous active-low reset
//   CLEAR_N     in   synchronous active-low flush (overrides READ/WRITE)
//   WRITE/READ  in   requests
//   DATA_IN     in   [WIDTH-1:0] write data
//   DATA_OUT    out  [WIDTH-1:0] registered read data
//   F_FULL_N    out  low when USE_DW == DEPTH
//   F_EMPTY_N   out  low when USE_DW == 0
//   F_AFULL_N   out  low when USE_DW >= AF_LEVEL
//   F_AEMPTY_N  out  low when USE_DW <= AE_LEVEL
//   USE_DW      out  [$clog2(DEPTH):0] occupancy
//   OVF/UDF     out  sticky error flags (macro builds only)
module fifo_param #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 32,
  parameter int AF_LEVEL = 28,
  parameter int AE_LEVEL = 4,
  localparam int AW      = $clog2(DEPTH),
  localparam int CW      = AW + 1
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             CLEAR_N,
  input  logic             WRITE,
  input  logic             READ,
  input  logic [WIDTH-1:0] DATA_IN,
  output logic [WIDTH-1:0] DATA_OUT,
  output logic             F_FULL_N,
  output logic             F_EMPTY_N,
  output logic             F_AFULL_N,
  output logic             F_AEMPTY_N,
`ifdef FIFO_PARAM_ERR_FLAGS_EN
  output logic             OVF,
  output logic             UDF,
`endif
  output logic [CW-1:0]    USE_DW
);

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  typedef enum logic [1:0] {S_EMPTY, S_PARTIAL, S_FULL} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [AW-1:0]      wptr, rptr;
  logic               rd_ok, wr_ok;
  logic [CW-1:0]      cnt_nxt;

  // A full FIFO still accepts a write when a read frees a slot on the same
  // edge. An empty FIFO never bypasses a write straight to DATA_OUT.
  assign rd_ok = READ && (state != S_EMPTY);
  assign wr_ok = WRITE && ((state != S_FULL) || rd_ok);

  always_comb begin
    cnt_nxt = USE_DW;
    if (wr_ok && !rd_ok)      cnt_nxt = USE_DW + CW'(1);
    else if (rd_ok && !wr_ok) cnt_nxt = USE_DW - CW'(1);
  end

  // Control FSM. The state tracks USE_DW and is the single source of the
  // accept decisions above.
  always_comb begin
    state_nxt = state;
    if (!CLEAR_N) begin
      state_nxt = S_EMPTY;
    end else begin
      case (state)
        S_EMPTY:   if (wr_ok) state_nxt = S_PARTIAL;
        S_PARTIAL: if (cnt_nxt == '0)           state_nxt = S_EMPTY;
                   else if (cnt_nxt == FULL_CNT) state_nxt = S_FULL;
        S_FULL:    if (rd_ok && !wr_ok) state_nxt = S_PARTIAL;
        default:   state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) state <= S_EMPTY;
    else          state <= state_nxt;
  end

  // Storage has no reset; its contents are don't-care until written.
  always_ff @(posedge CLOCK) begin
    if (CLEAR_N && wr_ok) mem[wptr] <= DATA_IN;
  end

  // Pointers, occupancy, read data and flags. The flags are computed from the
  // next occupancy, so they change on the same edge as USE_DW.
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      wptr       <= '0;
      rptr       <= '0;
      USE_DW     <= '0;
      DATA_OUT   <= '0;
      F_FULL_N   <= 1'b1;
      F_EMPTY_N  <= 1'b0;
      F_AFULL_N  <= 1'b1;
      F_AEMPTY_N <= 1'b0;
    end else if (!CLEAR_N) begin
      wptr       <= '0;
      rptr       <= '0;
      USE_DW     <= '0;
      DATA_OUT   <= '0;
      F_FULL_N   <= 1'b1;
      F_EMPTY_N  <= 1'b0;
      F_AFULL_N  <= 1'b1;
      F_AEMPTY_N <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(1);
      if (rd_ok) begin
        rptr     <= rptr + AW'(1);
        DATA_OUT <= mem[rptr];
      end
      USE_DW     <= cnt_nxt;
      F_FULL_N   <= (cnt_nxt != FULL_CNT);
      F_EMPTY_N  <= (cnt_nxt != '0);
      F_AFULL_N  <= !(cnt_nxt >= AF_CNT);
      F_AEMPTY_N <= !(cnt_nxt <= AE_CNT);
    end
  end

`ifdef FIFO_PARAM_ERR_FLAGS_EN
  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      OVF <= 1'b0;
      UDF <= 1'b0;
    end else if (!CLEAR_N) begin
      OVF <= 1'b0;
      UDF <= 1'b0;
    end else begin
      if (WRITE && !wr_ok) OVF <= 1'b1;
      if (READ && !rd_ok)  UDF <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_param.sv
// tb_fifo_param: directed self-checking bench for fifo_param at its default
// parameters (8 x 32, AF 28, AE 4).
module tb_fifo_param;

  logic       CLOCK, RESET_N, CLEAR_N, WRITE, READ;
  logic [7:0] DATA_IN, DATA_OUT;
  logic       F_FULL_N, F_EMPTY_N, F_AFULL_N, F_AEMPTY_N;
  logic [5:0] USE_DW;
`ifdef FIFO_PARAM_ERR_FLAGS_EN
  logic       OVF, UDF;
`endif

  int compared   = 0;
  int mismatched = 0;

  fifo_param dut (
    .CLOCK      (CLOCK),
    .RESET_N    (RESET_N),
    .CLEAR_N    (CLEAR_N),
    .WRITE      (WRITE),
    .READ       (READ),
    .DATA_IN    (DATA_IN),
    .DATA_OUT   (DATA_OUT),
    .F_FULL_N   (F_FULL_N),
    .F_EMPTY_N  (F_EMPTY_N),
    .F_AFULL_N  (F_AFULL_N),
    .F_AEMPTY_N (F_AEMPTY_N),
`ifdef FIFO_PARAM_ERR_FLAGS_EN
    .OVF        (OVF),
    .UDF        (UDF),
`endif
    .USE_DW     (USE_DW)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      $error("%s differs", tag);
    end
  endtask

  // One clock with the given requests; returns 1 time unit after the edge
  // with the requests dropped.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d);
    WRITE = w; READ = r; DATA_IN = d;
    @(posedge CLOCK);
    #1;
    WRITE = 1'b0; READ = 1'b0;
  endtask

  initial begin
    RESET_N = 1'b0; CLEAR_N = 1'b1; WRITE = 1'b0; READ = 1'b0; DATA_IN = '0;
    #12;
    chk("rst_empty_n",  F_EMPTY_N,  0);
    chk("rst_full_n",   F_FULL_N,   1);
    chk("rst_afull_n",  F_AFULL_N,  1);
    chk("rst_aempty_n", F_AEMPTY_N, 0);
    chk("rst_use",      USE_DW,     0);
    chk("rst_dout",     DATA_OUT,   0);
    @(posedge CLOCK); #1;
    RESET_N = 1'b1;

    // Reads on an empty FIFO are rejected.
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    chk("udr_use",     USE_DW,    0);
    chk("udr_empty_n", F_EMPTY_N, 0);
    chk("udr_aempty_n",F_AEMPTY_N,0);
    chk("udr_full_n",  F_FULL_N,  1);
    chk("udr_dout",    DATA_OUT,  0);
`ifdef FIFO_PARAM_ERR_FLAGS_EN
    chk("udr_udf", UDF, 1);
    chk("udr_ovf", OVF, 0);
`endif

    // Single word.
    cyc(1, 0, 8'hA5);
    chk("one_use",     USE_DW,    1);
    chk("one_empty_n", F_EMPTY_N, 1);
    chk("one_aempty_n",F_AEMPTY_N,0);
    chk("one_dout_pre",DATA_OUT,  0);
    cyc(0, 1, 0);
    chk("one_dout",    DATA_OUT,  8'hA5);
    chk("one_use0",    USE_DW,    0);
    chk("one_empty0",  F_EMPTY_N, 0);

    // Fill with 0..31, watching the flag thresholds.
    for (int i = 0; i < 32; i++) begin
      cyc(1, 0, 8'(i));
      if (i == 3)  chk("fill4_aempty_n",  F_AEMPTY_N, 0);
      if (i == 4)  chk("fill5_aempty_n",  F_AEMPTY_N, 1);
      if (i == 26) chk("fill27_afull_n",  F_AFULL_N,  1);
      if (i == 27) chk("fill28_afull_n",  F_AFULL_N,  0);
      if (i == 30) chk("fill31_full_n",   F_FULL_N,   1);
    end
    chk("full_use",    USE_DW,   32);
    chk("full_full_n", F_FULL_N, 0);
    cyc(1, 0, 8'hFF);
    chk("ovw_use",     USE_DW,   32);
    chk("ovw_full_n",  F_FULL_N, 0);
`ifdef FIFO_PARAM_ERR_FLAGS_EN
    chk("ovw_ovf", OVF, 1);
`endif
    for (int i = 0; i < 32; i++) begin
      cyc(0, 1, 0);
      chk($sformatf("drain_%0d", i), DATA_OUT, i);
      if (i == 0) chk("drain_full_n", F_FULL_N, 1);
    end
    chk("drain_use",     USE_DW,    0);
    chk("drain_empty_n", F_EMPTY_N, 0);

    // Wrap-around across the pointer boundary.
    for (int i = 0; i < 20; i++) cyc(1, 0, 8'(50 + i));
    chk("wrap_use20", USE_DW, 20);
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 0);
      chk($sformatf("wrapa_%0d", i), DATA_OUT, 50 + i);
    end
    for (int i = 0; i < 20; i++) cyc(1, 0, 8'(100 + i));
    for (int i = 0; i < 20; i++) begin
      cyc(0, 1, 0);
      chk($sformatf("wrapb_%0d", i), DATA_OUT, 100 + i);
    end
    chk("wrap_use0", USE_DW, 0);

    // Simultaneous read/write on a full FIFO.
    for (int i = 0; i < 32; i++) cyc(1, 0, 8'(i));
    cyc(1, 1, 8'h55);
    chk("rwf_use",    USE_DW,   32);
    chk("rwf_full_n", F_FULL_N, 0);
    chk("rwf_dout",   DATA_OUT, 0);
    for (int i = 1; i < 33; i++) begin
      cyc(0, 1, 0);
      chk($sformatf("rwf_drain_%0d", i), DATA_OUT, (i == 32) ? 32'h55 : i);
    end
    chk("rwf_use0", USE_DW, 0);

    // Simultaneous read/write on an empty FIFO: no bypass.
    cyc(1, 1, 8'h77);
    chk("rwe_use",     USE_DW,    1);
    chk("rwe_dout",    DATA_OUT,  8'h55);
    chk("rwe_empty_n", F_EMPTY_N, 1);
    cyc(0, 1, 0);
    chk("rwe_dout2",   DATA_OUT,  8'h77);
    chk("rwe_use0",    USE_DW,    0);

    // Synchronous clear with a concurrent write.
    for (int i = 0; i < 10; i++) cyc(1, 0, 8'(10 + i));
    chk("clr_pre_use", USE_DW, 10);
    CLEAR_N = 1'b0;
    cyc(1, 0, 8'hEE);
    CLEAR_N = 1'b1;
    chk("clr_use",      USE_DW,     0);
    chk("clr_empty_n",  F_EMPTY_N,  0);
    chk("clr_aempty_n", F_AEMPTY_N, 0);
    chk("clr_dout",     DATA_OUT,   0);
`ifdef FIFO_PARAM_ERR_FLAGS_EN
    chk("clr_ovf", OVF, 0);
    chk("clr_udf", UDF, 0);
`endif
    cyc(0, 1, 0);
    chk("clr_rd_use",  USE_DW,   0);
    chk("clr_rd_dout", DATA_OUT, 0);

    // Asynchronous reset mid-cycle.
    cyc(1, 0, 8'h09);
    cyc(1, 0, 8'h08);
    cyc(1, 0, 8'h07);
    cyc(0, 1, 0);
    chk("ar_pre_dout", DATA_OUT, 8'h09);
    chk("ar_pre_use",  USE_DW,   2);
    #2;
    RESET_N = 1'b0;
    #1;
    chk("ar_use",      USE_DW,     0);
    chk("ar_dout",     DATA_OUT,   0);
    chk("ar_empty_n",  F_EMPTY_N,  0);
    chk("ar_aempty_n", F_AEMPTY_N, 0);
    @(posedge CLOCK); #1;
    RESET_N = 1'b1;
    cyc(0, 1, 0);
    chk("ar_post_use", USE_DW, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
